// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX busy stalls,
// taken-branch IF/ID flushes, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int ZERO_REG    = 31,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rn,
  input  logic [REG_W-1:0] ifid_rm,
  input  logic             ifid_rn_used,
  input  logic             ifid_rm_used,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             control_off,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    MCBUSY = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // Reload values: the cycle that enters LSTALL/FLUSH is itself the first
  // stall/flush cycle, so the counter covers the remaining ones minus one.
  localparam logic [1:0]       LL_RELOAD = 2'((LOAD_LAT    > 1) ? LOAD_LAT    - 2 : 0);
  localparam logic [1:0]       FD_RELOAD = 2'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);
  localparam logic [REG_W-1:0] ZERO_IDX  = REG_W'(ZERO_REG);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       hazard;
  logic       branch_ok;

  assign hazard = idex_mem_read && (idex_rd != ZERO_IDX) &&
                  (((idex_rd == ifid_rn) && ifid_rn_used) ||
                   ((idex_rd == ifid_rm) && ifid_rm_used));

  assign branch_ok = branch_taken && ((state == IDLE) || (state == LSTALL));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves a variable unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (branch_ok) begin
      if (FLUSH_DEPTH > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FD_RELOAD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (mc_start) begin
            state_nxt = MCBUSY;
          end else if (hazard && (LOAD_LAT > 1)) begin
            state_nxt = LSTALL;
            cnt_nxt   = LL_RELOAD;
          end
        end
        LSTALL: begin
          if (cnt == 2'd0) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 2'd1;
        end
        MCBUSY: begin
          if (mc_done) state_nxt = IDLE;
        end
        FLUSH: begin
          if (branch_taken)       cnt_nxt   = FD_RELOAD;
          else if (cnt == 2'd0)   state_nxt = IDLE;
          else                    cnt_nxt   = cnt - 2'd1;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Outputs are gated by reset_n directly so an asserted reset forces the
  // defaults in the same cycle, even though hazard/branch are combinational.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    control_off = 1'b0;
    if_flush    = 1'b0;
    if (reset_n) begin
      if (branch_ok) begin
        if_flush    = 1'b1;
        control_off = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (!mc_start && hazard) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              control_off = 1'b1;
            end
          end
          LSTALL: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            control_off = 1'b1;
          end
          MCBUSY: begin
            if (!mc_done) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_write = 1'b0;
            end
          end
          FLUSH: begin
            if_flush    = 1'b1;
            control_off = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: a driver pushes hand-computed
// expectations into a scoreboard queue; a monitor pops and compares each cycle.
module tb_hazard_ctrl;

  localparam logic [4:0] DEF = 5'b11100;  // {pc, ifid, idex, ctrl_off, flush}
  localparam logic [4:0] STL = 5'b00110;
  localparam logic [4:0] FLS = 5'b11111;
  localparam logic [4:0] BSY = 5'b00000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       idex_mem_read;
  logic [4:0] idex_rd, ifid_rn, ifid_rm;
  logic       ifid_rn_used, ifid_rm_used;
  logic       branch_taken, mc_start, mc_done, stat_clr;

  logic        pc_a, ifw_a, idw_a, co_a, fl_a;
  logic [1:0]  cnt_a;
  logic        pc_b, ifw_b, idw_b, co_b, fl_b;
  logic [15:0] cnt_b;

  typedef struct {
    int          row;
    logic [4:0]  out_a;
    logic [1:0]  cnt_a;
    bit          chk_b;
    logic [4:0]  out_b;
    logic [15:0] cnt_b;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   row_no = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(2)) u_a (
    .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_rn_used(ifid_rn_used),
    .ifid_rm_used(ifid_rm_used), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .stat_clr(stat_clr), .pc_write(pc_a), .ifid_write(ifw_a),
    .idex_write(idw_a), .control_off(co_a), .if_flush(fl_a), .stall_count(cnt_a)
  );

  hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_rn_used(ifid_rn_used),
    .ifid_rm_used(ifid_rm_used), .branch_taken(branch_taken), .mc_start(mc_start),
    .mc_done(mc_done), .stat_clr(stat_clr), .pc_write(pc_b), .ifid_write(ifw_b),
    .idex_write(idw_b), .control_off(co_b), .if_flush(fl_b), .stall_count(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // One clock cycle of stimulus, applied mid-cycle, plus its expectation.
  task automatic row(input logic rst, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rn, input logic [4:0] rm, input logic rnu,
                     input logic rmu, input logic br, input logic ms, input logic md,
                     input logic clr, input logic [4:0] ea, input logic [1:0] ca,
                     input bit chkb, input logic [4:0] eb, input logic [15:0] cb);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst; idex_mem_read = mr; idex_rd = rd; ifid_rn = rn; ifid_rm = rm;
    ifid_rn_used = rnu; ifid_rm_used = rmu; branch_taken = br; mc_start = ms;
    mc_done = md; stat_clr = clr;
    e.row = row_no; e.out_a = ea; e.cnt_a = ca; e.chk_b = chkb; e.out_b = eb; e.cnt_b = cb;
    sb.push_back(e);
    row_no++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("row%0d_a_out", e.row), {27'd0, pc_a, ifw_a, idw_a, co_a, fl_a}, {27'd0, e.out_a});
        check($sformatf("row%0d_a_cnt", e.row), {30'd0, cnt_a}, {30'd0, e.cnt_a});
        if (e.chk_b) begin
          check($sformatf("row%0d_b_out", e.row), {27'd0, pc_b, ifw_b, idw_b, co_b, fl_b}, {27'd0, e.out_b});
          check($sformatf("row%0d_b_cnt", e.row), {16'd0, cnt_b}, {16'd0, e.cnt_b});
        end
      end
    end
  end

  initial begin : driver
    reset_n = 1'b0; idex_mem_read = 1'b0; idex_rd = '0; ifid_rn = '0; ifid_rm = '0;
    ifid_rn_used = 1'b0; ifid_rm_used = 1'b0; branch_taken = 1'b0; mc_start = 1'b0;
    mc_done = 1'b0; stat_clr = 1'b0;
    //   rst mr rd  rn  rm  nu mu br ms md clr  exp_a cnt  b  exp_b cnt_b
    // reset forces defaults despite hazard inputs
    row(0, 1, 3,  3,  0,  1, 0, 0, 0, 0, 0,  DEF, 0,  1, DEF, 0);   // 0
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  1, DEF, 0);   // 1
    // load x3; add x4 = x3 + x5 (A: 3-cycle stall, B: 1-cycle stall)
    row(1, 1, 3,  3,  5,  1, 1, 0, 0, 0, 0,  STL, 0,  1, STL, 0);   // 2
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  STL, 1,  1, DEF, 1);   // 3
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  STL, 2,  1, DEF, 1);   // 4
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 3,  1, DEF, 1);   // 5
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1,  DEF, 3,  0, DEF, 0);   // 6 clear
    // hazard on rm only
    row(1, 1, 7,  2,  7,  1, 1, 0, 0, 0, 0,  STL, 0,  0, DEF, 0);   // 7
    row(1, 1, 7,  2,  7,  1, 1, 0, 0, 0, 0,  STL, 1,  0, DEF, 0);   // 8
    row(1, 1, 7,  2,  7,  1, 1, 0, 0, 0, 0,  STL, 2,  0, DEF, 0);   // 9
    // rm match with rm_used=0, then idex_rd = zero register: no stall
    row(1, 1, 7,  2,  7,  1, 0, 0, 0, 0, 0,  DEF, 3,  0, DEF, 0);   // 10
    row(1, 1, 31, 31, 31, 1, 1, 0, 0, 0, 0,  DEF, 3,  0, DEF, 0);   // 11
    // stall again: counter saturates at 3, clear mid-stall wins
    row(1, 1, 7,  2,  7,  1, 1, 0, 0, 0, 0,  STL, 3,  0, DEF, 0);   // 12
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1,  STL, 3,  0, DEF, 0);   // 13
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  STL, 0,  0, DEF, 0);   // 14
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 1,  0, DEF, 0);   // 15
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1,  DEF, 1,  0, DEF, 0);   // 16 clear
    // branch in 2nd stall cycle: stall cancelled, 2 flush cycles
    row(1, 1, 3,  3,  0,  1, 0, 0, 0, 0, 0,  STL, 0,  0, DEF, 0);   // 17
    row(1, 0, 0,  0,  0,  0, 0, 1, 0, 0, 0,  FLS, 1,  0, DEF, 0);   // 18
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  FLS, 1,  0, DEF, 0);   // 19
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 1,  0, DEF, 0);   // 20
    // branch beats mc_start and hazard; re-branch reloads; mc_start ignored in FLUSH
    row(1, 1, 3,  3,  0,  1, 0, 1, 1, 0, 0,  FLS, 1,  0, DEF, 0);   // 21
    row(1, 0, 0,  0,  0,  0, 0, 1, 0, 0, 0,  FLS, 1,  0, DEF, 0);   // 22
    row(1, 0, 0,  0,  0,  0, 0, 0, 1, 0, 0,  FLS, 1,  0, DEF, 0);   // 23
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 1,  0, DEF, 0);   // 24
    // mc_start beats hazard; busy 4 cycles; branch ignored while busy
    row(1, 1, 3,  3,  0,  1, 0, 0, 1, 0, 0,  DEF, 1,  0, DEF, 0);   // 25
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  BSY, 1,  0, DEF, 0);   // 26
    row(1, 0, 0,  0,  0,  0, 0, 1, 0, 0, 0,  BSY, 2,  0, DEF, 0);   // 27
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  BSY, 3,  0, DEF, 0);   // 28
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  BSY, 3,  0, DEF, 0);   // 29
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0,  DEF, 3,  0, DEF, 0);   // 30
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0,  DEF, 3,  0, DEF, 0);   // 31 stray mc_done
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1,  DEF, 3,  0, DEF, 0);   // 32 clear
    // async reset mid-flush, then mid-stall: no residual cycles afterwards
    row(1, 0, 0,  0,  0,  0, 0, 1, 0, 0, 0,  FLS, 0,  0, DEF, 0);   // 33
    row(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 34
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 35
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 36
    row(1, 1, 3,  3,  0,  1, 0, 0, 0, 0, 0,  STL, 0,  0, DEF, 0);   // 37
    row(0, 1, 3,  3,  0,  1, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 38
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 39
    row(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  DEF, 0,  0, DEF, 0);   // 40

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
